// File: rtl/fu_operand_stage.sv
// -----------------------------------------------------------------------------
// fu_operand_stage
//
// Operand fetch / issue stage in front of a single-cycle function unit.
// Holds an 8 x 16-bit register file with two read ports (ra, rb) and one
// write port. An accepted instruction registers its operands and function
// select toward the function unit (ISSUE). During the following cycle the
// function unit computes combinationally from those registers, and its result
// and flags are committed at the end of that cycle (EXE). Issue-to-commit
// latency is two rising edges, and throughput is one instruction per cycle.
//
// A read-after-write hazard exists when the instruction presented on instr_in
// reads the register that the instruction in EXE is about to write.
//   OPFWD_EN defined   : the hazarding operand is taken straight from f_in,
//                        so the stream never stalls.
//   OPFWD_EN undefined : instr_ready_out drops for one cycle while the write
//                        lands. The instruction then issues from the updated
//                        register file.
//
// Parameters
//   ZERO_R0   1: r0 always reads as zero and writes to it are dropped.
//             The flag register is still updated by an instruction targeting r0.
//   NZ_RESET  value loaded into nz_flags_out by reset.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   instr_valid_in   instruction word present on instr_in
//   instr_ready_out  stage accepts instr_in this cycle (valid & ready = transfer)
//   instr_in         [15:12] fs, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] unused
//   a_out, b_out     registered operands to the function unit
//   fs_out           registered function select (fs_t width, 4 bits)
//   exe_valid_out    a_out/b_out/fs_out carry a live instruction
//   f_in, nz_in      function unit result and flags for the EXE instruction
//   nz_flags_out     last committed flags
//   dbg_addr_in      debug register select
//   dbg_data_out     combinational register read; the r0 rule applies
//
// Configuration macro: OPFWD_EN (operand forwarding from f_in).
// -----------------------------------------------------------------------------
module fu_operand_stage #(
  parameter int         ZERO_R0  = 1,
  parameter logic [1:0] NZ_RESET = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [15:0] instr_in,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  output logic [3:0]  fs_out,
  output logic        exe_valid_out,
  input  logic [15:0] f_in,
  input  logic [1:0]  nz_in,
  output logic [1:0]  nz_flags_out,
  input  logic [2:0]  dbg_addr_in,
  output logic [15:0] dbg_data_out
);

  localparam int DATA_W = 16;
  localparam int FS_W   = 4;
  localparam int NREG   = 8;
  localparam bit ZR     = (ZERO_R0 != 0);

  // Instruction fields
  logic [FS_W-1:0] fs_dec;
  logic [2:0]      rd_dec;
  logic [2:0]      ra_dec;
  logic [2:0]      rb_dec;
  logic            unused_bits;

  assign fs_dec      = instr_in[15:12];
  assign rd_dec      = instr_in[11:9];
  assign ra_dec      = instr_in[8:6];
  assign rb_dec      = instr_in[5:3];
  assign unused_bits = ^instr_in[2:0];

  // Architectural state
  logic [DATA_W-1:0] rf [NREG];
  logic [1:0]        nz_p2;

  // ISSUE -> EXE pipeline registers
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [FS_W-1:0]   fs_p1;
  logic [2:0]        rd_p1;
  logic              vld_p1;

  // Register file read ports. r0 reads as zero when ZERO_R0 is set.
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;

  always_comb begin
    ra_val = rf[ra_dec];
    if (ZR && (ra_dec == 3'd0)) ra_val = '0;
  end

  always_comb begin
    rb_val = rf[rb_dec];
    if (ZR && (rb_dec == 3'd0)) rb_val = '0;
  end

  // The debug port sees the register file before this cycle's write lands.
  always_comb begin
    dbg_data_out = rf[dbg_addr_in];
    if (ZR && (dbg_addr_in == 3'd0)) dbg_data_out = '0;
  end

  // Hazard detection against the instruction now in EXE. A discarded r0
  // write never produces a value worth waiting for.
  logic exe_writes;
  logic hz_a;
  logic hz_b;

  assign exe_writes = vld_p1 && !(ZR && (rd_p1 == 3'd0));
  assign hz_a       = exe_writes && (ra_dec == rd_p1);
  assign hz_b       = exe_writes && (rb_dec == rd_p1);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

`ifdef OPFWD_EN
  // Forward the in-flight result so a dependent instruction issues at once.
  assign instr_ready_out = 1'b1;
  assign op_a            = hz_a ? f_in : ra_val;
  assign op_b            = hz_b ? f_in : rb_val;
`else
  // Hold off the dependent instruction for the one cycle its source is written.
  assign instr_ready_out = !(hz_a || hz_b);
  assign op_a            = ra_val;
  assign op_b            = rb_val;
`endif

  logic xfer;
  assign xfer = instr_valid_in && instr_ready_out;

  // ---- stage boundary: ISSUE -> EXE ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      fs_p1  <= '0;
      rd_p1  <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        a_p1  <= op_a;
        b_p1  <= op_b;
        fs_p1 <= fs_dec;
        rd_p1 <= rd_dec;
      end
    end
  end

  assign a_out         = a_p1;
  assign b_out         = b_p1;
  assign fs_out        = fs_p1;
  assign exe_valid_out = vld_p1;

  // ---- stage boundary: EXE -> commit ----
  logic wr_en;
  assign wr_en = vld_p1 && !(ZR && (rd_p1 == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      nz_p2 <= NZ_RESET;
    end else begin
      if (vld_p1) nz_p2 <= nz_in;
      if (wr_en) rf[rd_p1] <= f_in;
    end
  end

  assign nz_flags_out = nz_p2;

endmodule

// File: tb/tb_fu_operand_stage.sv
module tb_fu_operand_stage;

  localparam logic [1:0] NZR = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [15:0] instr_in;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [3:0]  fs_out;
  logic        exe_valid_out;
  logic [15:0] f_in;
  logic [1:0]  nz_in;
  logic [1:0]  nz_flags_out;
  logic [2:0]  dbg_addr_in;
  logic [15:0] dbg_data_out;

  always #5 clk = ~clk;

  fu_operand_stage #(.ZERO_R0(1), .NZ_RESET(NZR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid_in (instr_valid_in),
    .instr_ready_out(instr_ready_out),
    .instr_in       (instr_in),
    .a_out          (a_out),
    .b_out          (b_out),
    .fs_out         (fs_out),
    .exe_valid_out  (exe_valid_out),
    .f_in           (f_in),
    .nz_in          (nz_in),
    .nz_flags_out   (nz_flags_out),
    .dbg_addr_in    (dbg_addr_in),
    .dbg_data_out   (dbg_data_out)
  );

  // Function unit stand-in: either a fixed value or a small ALU.
  logic        fu_auto;
  logic [15:0] man_f;
  logic [1:0]  man_nz;

  function automatic logic [15:0] fu_f(input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] fs);
    case (fs)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      default: return a + b + {12'h000, fs};
    endcase
  endfunction

  function automatic logic [1:0] fu_nz(input logic [15:0] f);
    return {f[15], (f == 16'h0000)};
  endfunction

  assign f_in  = fu_auto ? fu_f(a_out, b_out, fs_out) : man_f;
  assign nz_in = fu_auto ? fu_nz(f_in) : man_nz;

  function automatic logic [15:0] mk(input logic [3:0] fs, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {fs, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [2:0] rsel();
    if ($urandom_range(0, 3) == 0) return 3'($urandom_range(0, 7));
    return 3'($urandom_range(0, 2));
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural model: registers and flags after all committed instructions.
  logic [15:0] arch [8];
  logic [1:0]  arch_nz;

  task automatic arch_reset();
    for (int i = 0; i < 8; i++) arch[i] = 16'h0000;
    arch_nz = NZR;
  endtask

  // Present an instruction until accepted (bounded), then drop valid.
  task automatic issue(input logic [15:0] ins, output bit ok);
    instr_in       = ins;
    instr_valid_in = 1'b1;
    ok             = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (instr_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] f;
    logic [1:0]  nz;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl [6];

  // Random-phase state
  logic [2:0]  ra, rb, rdx, pend_rd;
  logic [15:0] pend_f, hold_a, hold_b, ea, eb;
  logic [3:0]  hold_fs;
  bit          pend_v, xfer, hz, exp_rdy, ok;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid_in = 1'b0; instr_in = 16'h0000; dbg_addr_in = 3'd0;
    fu_auto = 1'b0; man_f = 16'h0000; man_nz = 2'b00;
    tbl[0] = '{mk(4'h1, 3'd1, 3'd0, 3'd0), 16'h0005, 2'b00, 16'h0000, 16'h0000, 16'h0005};
    tbl[1] = '{mk(4'h2, 3'd2, 3'd1, 3'd0), 16'h0003, 2'b00, 16'h0005, 16'h0000, 16'h0003};
    tbl[2] = '{mk(4'h3, 3'd3, 3'd1, 3'd2), 16'h0008, 2'b00, 16'h0005, 16'h0003, 16'h0008};
    tbl[3] = '{mk(4'h4, 3'd0, 3'd3, 3'd1), 16'h1234, 2'b10, 16'h0008, 16'h0005, 16'h0000};
    tbl[4] = '{mk(4'h5, 3'd6, 3'd0, 3'd3), 16'h8000, 2'b10, 16'h0000, 16'h0008, 16'h8000};
    tbl[5] = '{mk(4'h6, 3'd7, 3'd6, 3'd7), 16'h00F0, 2'b00, 16'h8000, 16'h0000, 16'h00F0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    instr_in = mk(4'h0, 3'd1, 3'd1, 3'd1);
    chk("rst_a", a_out, 16'h0000);
    chk("rst_b", b_out, 16'h0000);
    chk("rst_fs", 16'(fs_out), 16'h0000);
    chk("rst_exe", 16'(exe_valid_out), 16'h0000);
    chk("rst_nz", 16'(nz_flags_out), 16'(NZR));
    chk("rst_ready", 16'(instr_ready_out), 16'h0001);
    for (int i = 0; i < 8; i++) begin
      dbg_addr_in = 3'(i);
      #1;
      chk("rst_dbg", dbg_data_out, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    arch_reset();
    @(posedge clk);
    #1;

    // Table of isolated instructions
    for (int i = 0; i < 6; i++) begin
      man_f  = tbl[i].f;
      man_nz = tbl[i].nz;
      issue(tbl[i].ins, ok);
      chk("tbl_accept", 16'(ok), 16'h0001);
      chk("tbl_a", a_out, tbl[i].ea);
      chk("tbl_b", b_out, tbl[i].eb);
      chk("tbl_fs", 16'(fs_out), 16'(tbl[i].ins[15:12]));
      chk("tbl_exe", 16'(exe_valid_out), 16'h0001);
      rdx = tbl[i].ins[11:9];
      dbg_addr_in = rdx;
      #1;
      chk("tbl_dbg_old", dbg_data_out, arch[rdx]);
      @(posedge clk);
      #1;
      if (rdx != 3'd0) arch[rdx] = tbl[i].f;
      arch_nz = tbl[i].nz;
      chk("tbl_exe_off", 16'(exe_valid_out), 16'h0000);
      chk("tbl_nz", 16'(nz_flags_out), 16'(tbl[i].nz));
      chk("tbl_rd", dbg_data_out, tbl[i].erd);
    end

    // Back-to-back dependent pair: r4 <- FFFF, then read r4 twice
    man_f = 16'hFFFF; man_nz = 2'b10;
    instr_in = mk(4'h0, 3'd4, 3'd1, 3'd2);
    instr_valid_in = 1'b1;
    @(negedge clk);
    chk("dep_ready0", 16'(instr_ready_out), 16'h0001);
    @(posedge clk);
    #1;
    chk("dep_a0", a_out, 16'h0005);
    chk("dep_b0", b_out, 16'h0003);
    instr_in = mk(4'h7, 3'd5, 3'd4, 3'd4);
    @(negedge clk);
`ifdef OPFWD_EN
    chk("dep_fwd_ready", 16'(instr_ready_out), 16'h0001);
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
`else
    chk("dep_stall_ready", 16'(instr_ready_out), 16'h0000);
    @(posedge clk);
    #1;
    chk("dep_bubble", 16'(exe_valid_out), 16'h0000);
    @(negedge clk);
    chk("dep_ready_back", 16'(instr_ready_out), 16'h0001);
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
`endif
    chk("dep_a1", a_out, 16'hFFFF);
    chk("dep_b1", b_out, 16'hFFFF);
    chk("dep_exe1", 16'(exe_valid_out), 16'h0001);
    @(posedge clk);
    #1;
    arch[4] = 16'hFFFF; arch[5] = 16'hFFFF; arch_nz = 2'b10;
    dbg_addr_in = 3'd4;
    #1;
    chk("dep_r4", dbg_data_out, 16'hFFFF);
    dbg_addr_in = 3'd5;
    #1;
    chk("dep_r5", dbg_data_out, 16'hFFFF);

    // r0 target followed by an r0 reader: no stall, flags still move
    man_f = 16'h1234; man_nz = 2'b10;
    instr_in = mk(4'h0, 3'd0, 3'd1, 3'd1);
    instr_valid_in = 1'b1;
    @(posedge clk);
    #1;
    instr_in = mk(4'h1, 3'd5, 3'd0, 3'd0);
    @(negedge clk);
    chk("r0_nostall", 16'(instr_ready_out), 16'h0001);
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
    chk("r0_a", a_out, 16'h0000);
    chk("r0_b", b_out, 16'h0000);
    chk("r0_nz", 16'(nz_flags_out), 16'h0002);
    dbg_addr_in = 3'd0;
    #1;
    chk("r0_read", dbg_data_out, 16'h0000);
    man_f = 16'h2222; man_nz = 2'b00;
    @(posedge clk);
    #1;
    arch[5] = 16'h2222; arch_nz = 2'b00;
    dbg_addr_in = 3'd5;
    #1;
    chk("r0_next_r5", dbg_data_out, 16'h2222);

    // Idle gap: operands hold, nothing is written
    man_f = 16'h0AAA; man_nz = 2'b00;
    issue(mk(4'h2, 3'd6, 3'd1, 3'd3), ok);
    chk("idle_accept", 16'(ok), 16'h0001);
    @(posedge clk);
    #1;
    arch[6] = 16'h0AAA;
    man_f = 16'hDEAD; man_nz = 2'b11;
    dbg_addr_in = 3'd6;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_exe", 16'(exe_valid_out), 16'h0000);
      chk("idle_a", a_out, 16'h0005);
      chk("idle_b", b_out, 16'h0008);
      chk("idle_fs", 16'(fs_out), 16'h0002);
      chk("idle_nz", 16'(nz_flags_out), 16'h0000);
      chk("idle_r6", dbg_data_out, 16'h0AAA);
    end

    // Reset during EXE of rd=5
    man_f = 16'hABCD; man_nz = 2'b11;
    issue(mk(4'h3, 3'd5, 3'd1, 3'd2), ok);
    #2;
    rst_n = 1'b0;
    #1;
    dbg_addr_in = 3'd5;
    #1;
    chk("mid_rst_exe", 16'(exe_valid_out), 16'h0000);
    chk("mid_rst_nz", 16'(nz_flags_out), 16'(NZR));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    arch_reset();
    #1;
    chk("mid_rst_r5", dbg_data_out, 16'h0000);
    chk("mid_rst_exe2", 16'(exe_valid_out), 16'h0000);
    chk("mid_rst_a", a_out, 16'h0000);
    @(posedge clk);
    #1;

    // Random stream against the in-order architectural model
    fu_auto = 1'b1;
    pend_v = 1'b0; xfer = 1'b0;
    hold_a = 16'h0000; hold_b = 16'h0000; hold_fs = 4'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!instr_valid_in || xfer) begin
        instr_valid_in = ($urandom_range(0, 9) < 8);
        instr_in = {4'($urandom_range(0, 15)), rsel(), rsel(), rsel(), 3'($urandom_range(0, 7))};
      end
      dbg_addr_in = 3'($urandom_range(0, 7));
      @(negedge clk);
      ra = instr_in[8:6];
      rb = instr_in[5:3];
      hz = pend_v && ((ra == pend_rd) || (rb == pend_rd)) && (pend_rd != 3'd0);
`ifdef OPFWD_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = !hz;
`endif
      chk("rnd_ready", 16'(instr_ready_out), 16'(exp_rdy));
      chk("rnd_dbg", dbg_data_out, arch[dbg_addr_in]);
      chk("rnd_nz", 16'(nz_flags_out), 16'(arch_nz));
      xfer = instr_valid_in && instr_ready_out;
      @(posedge clk);
      #1;
      if (pend_v) begin
        if (pend_rd != 3'd0) arch[pend_rd] = pend_f;
        arch_nz = fu_nz(pend_f);
        pend_v = 1'b0;
      end
      if (xfer) begin
        ea = arch[ra];
        eb = arch[rb];
        hold_a = ea;
        hold_b = eb;
        hold_fs = instr_in[15:12];
        pend_v = 1'b1;
        pend_rd = instr_in[11:9];
        pend_f = fu_f(ea, eb, hold_fs);
      end
      chk("rnd_a", a_out, hold_a);
      chk("rnd_b", b_out, hold_b);
      chk("rnd_fs", 16'(fs_out), 16'(hold_fs));
      chk("rnd_exe", 16'(exe_valid_out), 16'(xfer));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fu_operand_stage.md
FU_OPERAND_STAGE -- requirements
Module: fu_operand_stage

Interface
REQ-001 Parameter ZERO_R0, default 1: when 1, r0 reads as 16'h0000 and writes to r0 are discarded.
REQ-002 Parameter NZ_RESET, default 2'b00: value of nz_flags_out after reset.
REQ-003 clk  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr_valid_in  input  1  instruction word present on instr_in.
REQ-006 instr_ready_out  output  1  block accepts instr_in this cycle; transfer occurs when valid and ready are both 1.
REQ-007 instr_in  input  16  [15:12] fs, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
REQ-008 a_out  output  16  registered operand A to the function unit a_in.
REQ-009 b_out  output  16  registered operand B to the function unit b_in.
REQ-010 fs_out  output  fs_t (4 bits, mycpu_pkg)  registered function select to the function unit fs_in.
REQ-011 exe_valid_out  output  1  a_out/b_out/fs_out hold a live instruction this cycle.
REQ-012 f_in  input  16  function unit result f_out.
REQ-013 nz_in  input  2  function unit flags nz_out.
REQ-014 nz_flags_out  output  2  flag register, last committed nz_in.
REQ-015 dbg_addr_in  input  3  debug register select.
REQ-016 dbg_data_out  output  16  combinational read of register dbg_addr_in, r0 rule applied.

Function
REQ-017 Register file: 8 x 16-bit, two read ports (ra, rb), one write port.
REQ-018 ISSUE: on accepted transfer in cycle N, a_out<=R[ra], b_out<=R[rb], fs_out<=instr_in[15:12], exe_valid_out<=1, and rd is latched internally at the same edge.
REQ-019 EXE: in cycle N+1 the function unit drives f_in/nz_in combinationally; at the end of N+1, R[rd]<=f_in and nz_flags_out<=nz_in.
REQ-020 Issue-to-commit latency is 2 rising edges; throughput is 1 instruction/cycle with no hazard.
REQ-021 No transfer in a cycle: exe_valid_out<=0 at the next edge, and a_out/b_out/fs_out hold their values.
REQ-022 exe_valid_out=0: no register write and no flag update.
REQ-023 Hazard: exe_valid_out=1 and (ra==rd_exe or rb==rd_exe) and rd_exe!=0 (r0 exemption only when ZERO_R0=1); handling per REQ-029/030.
REQ-024 Write to r0 with ZERO_R0=1: nz_flags_out still updates, R[0] unchanged.
REQ-025 Register write and debug read of the same register in the same cycle: dbg_data_out returns the old value.
REQ-026 instr_ready_out is combinational from the current state and instr_in only; it never depends on f_in.

Reset
REQ-027 rst_n low, asynchronously: all R[i]=0, a_out=0, b_out=0, fs_out=0, exe_valid_out=0, nz_flags_out=NZ_RESET, internal rd=0, instr_ready_out=1.
REQ-028 Reset asserted mid-operation discards the in-flight EXE instruction; no write occurs at any edge while rst_n=0.

Configuration
REQ-029 Macro OPFWD_EN defined: on a hazard, the matching operand is taken from f_in in place of R[], instr_ready_out stays 1, and no bubble is inserted.
REQ-030 Macro OPFWD_EN undefined: on a hazard, instr_ready_out=0 for exactly one cycle; the instruction issues next cycle from the updated register file.

Verification
REQ-031 Reset check: rst_n=0 -> all outputs at their reset values, dbg_data_out=0 for all 8 addresses, instr_ready_out=1.
REQ-032 Independent stream: preload R1=16'h0005, R2=16'h0003, issue rd=3 ra=1 rb=2, bench drives f_in=16'h0008 and nz_in=2'b00 in EXE -> a_out=5 and b_out=3 one edge after issue; R3=8 at the next edge.
REQ-033 Back-to-back dependent: rd=4 producing f_in=16'hFFFF, then ra=4 rb=4 -> OPFWD_EN: a_out=b_out=FFFF on the next edge with no bubble; without the macro: one cycle with instr_ready_out=0, then the same operands.
REQ-034 r0 rule: rd=0 with f_in=16'h1234 and nz_in=2'b10 -> R0 still reads 0, nz_flags_out=2'b10, and a following ra=0 raises no stall.
REQ-035 Reset mid-EXE: rst_n pulsed low during EXE of rd=5 -> R5=0 and exe_valid_out=0 after release.
REQ-036 Idle gap: drop valid for 3 cycles -> exe_valid_out=0, no register or flag change, and operand outputs hold their values.
